// File: rtl/btn_conditioner.sv
// Multi-channel button/switch conditioner: two-flop synchroniser, debounce filter,
// and registered press, release and long-press pulses per channel.
module btn_conditioner #(
    parameter int N               = 5,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int HOLD_CYCLES     = 50000000
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] btn_in,
    output logic [N-1:0] db_level,
    output logic [N-1:0] press_pulse,
    output logic [N-1:0] release_pulse,
    output logic [N-1:0] long_press
);

    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(HOLD_CYCLES);

    logic [N-1:0]  sync1_q, sync2_q;
    logic [N-1:0]  db_q, db_d;
    logic [N-1:0]  press_q, press_d;
    logic [N-1:0]  rel_q, rel_d;
    logic [N-1:0]  long_q, long_d;
    logic [N-1:0]  done_q, done_d;
    logic [DW-1:0] db_cnt_q [N];
    logic [DW-1:0] db_cnt_d [N];
    logic [HW-1:0] hold_q [N];
    logic [HW-1:0] hold_d [N];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= '0;
            sync2_q <= '0;
            db_q    <= '0;
            press_q <= '0;
            rel_q   <= '0;
            long_q  <= '0;
            done_q  <= '0;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= '0;
                hold_q[i]   <= '0;
            end
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            press_q <= press_d;
            rel_q   <= rel_d;
            long_q  <= long_d;
            done_q  <= done_d;
            for (int i = 0; i < N; i++) begin
                db_cnt_q[i] <= db_cnt_d[i];
                hold_q[i]   <= hold_d[i];
            end
        end
    end

    always_comb begin
        db_d    = db_q;
        press_d = '0;
        rel_d   = '0;
        long_d  = '0;
        done_d  = done_q;
        for (int i = 0; i < N; i++) begin
            db_cnt_d[i] = db_cnt_q[i];
            hold_d[i]   = hold_q[i];
        end

        for (int i = 0; i < N; i++) begin
            // Any cycle where the synchronised input agrees with the accepted level restarts the filter.
            if (sync2_q[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_cnt_d[i] = '0;
                db_d[i]     = ~db_q[i];
                press_d[i]  = ~db_q[i];
                rel_d[i]    = db_q[i];
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + DW'(1);
            end

            // A release on the terminal hold edge wins, so long_press is suppressed.
            if (press_d[i] || rel_d[i]) begin
                hold_d[i] = '0;
                done_d[i] = 1'b0;
            end else if (db_q[i] && !done_q[i]) begin
                if (hold_q[i] == HOLD_LAST) begin
                    hold_d[i] = HOLD_MAX;
                    long_d[i] = 1'b1;
                    done_d[i] = 1'b1;
                end else begin
                    hold_d[i] = hold_q[i] + HW'(1);
                end
            end
        end
    end

    assign db_level      = db_q;
    assign press_pulse   = press_q;
    assign release_pulse = rel_q;
    assign long_press    = long_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner (N=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10) with a
// per-cycle expectation queue compared against the DUT outputs after each clock edge.
module tb_btn_conditioner;

    localparam int N  = 5;
    localparam int DB = 4;
    localparam int HD = 10;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] btn_in = '0;
    logic [N-1:0] db_level, press_pulse, release_pulse, long_press;

    always #10 clk = ~clk;

    btn_conditioner #(
        .N               (N),
        .DEBOUNCE_CYCLES (DB),
        .HOLD_CYCLES     (HD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .btn_in        (btn_in),
        .db_level      (db_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_press    (long_press)
    );

    typedef struct {
        string          tag;
        logic [4*N-1:0] exp;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;

    task automatic expect_now(input string tag, input logic [N-1:0] db, input logic [N-1:0] pr,
                              input logic [N-1:0] rl, input logic [N-1:0] lp);
        exp_t e;
        e.tag = tag;
        e.exp = {db, pr, rl, lp};
        sb.push_back(e);
    endtask

    task automatic check_out();
        exp_t           e;
        logic [4*N-1:0] obs;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard: observed empty queue, required a pending expectation");
            return;
        end
        e   = sb.pop_front();
        obs = {db_level, press_pulse, release_pulse, long_press};
        assert (obs === e.exp) else begin
            n_fail++;
            $error("FAIL %s: observed db=%b pr=%b rl=%b lp=%b expected db=%b pr=%b rl=%b lp=%b",
                   e.tag, obs[19:15], obs[14:10], obs[9:5], obs[4:0],
                   e.exp[19:15], e.exp[14:10], e.exp[9:5], e.exp[4:0]);
        end
    endtask

    task automatic steps(input int n, input string tag, input logic [N-1:0] db,
                         input logic [N-1:0] pr, input logic [N-1:0] rl, input logic [N-1:0] lp);
        for (int k = 0; k < n; k++) begin
            expect_now(tag, db, pr, rl, lp);
            @(posedge clk);
            #1;
            check_out();
        end
    endtask

    initial begin
        // 1: inputs high through reset, then all channels press together
        btn_in = 5'b11111;
        rst_n  = 1'b0;
        steps(3, "t1_in_reset", 5'h00, 5'h00, 5'h00, 5'h00);
        rst_n = 1'b1;
        steps(5, "t1_sync",  5'h00, 5'h00, 5'h00, 5'h00);
        steps(1, "t1_press", 5'h1f, 5'h1f, 5'h00, 5'h00);
        steps(9, "t1_hold",  5'h1f, 5'h00, 5'h00, 5'h00);
        steps(1, "t1_long",  5'h1f, 5'h00, 5'h00, 5'h1f);
        steps(2, "t1_after", 5'h1f, 5'h00, 5'h00, 5'h00);
        btn_in = 5'b00000;
        steps(5, "t1_relwait", 5'h1f, 5'h00, 5'h00, 5'h00);
        steps(1, "t1_rel",     5'h00, 5'h00, 5'h1f, 5'h00);
        steps(2, "t1_idle",    5'h00, 5'h00, 5'h00, 5'h00);

        // 2: clean press on channel 0
        btn_in = 5'b00001;
        steps(5, "t2_sync",    5'h00, 5'h00, 5'h00, 5'h00);
        steps(1, "t2_press",   5'h01, 5'h01, 5'h00, 5'h00);
        steps(1, "t2_pr_low",  5'h01, 5'h00, 5'h00, 5'h00);
        btn_in = 5'b00000;
        steps(5, "t2_relwait", 5'h01, 5'h00, 5'h00, 5'h00);
        steps(1, "t2_rel",     5'h00, 5'h00, 5'h01, 5'h00);
        steps(2, "t2_idle",    5'h00, 5'h00, 5'h00, 5'h00);

        // 3: channel 1 bounces every 2 cycles, then settles high
        for (int k = 0; k < 6; k++) begin
            btn_in[1] = ~btn_in[1];
            steps(2, "t3_bounce", 5'h00, 5'h00, 5'h00, 5'h00);
        end
        btn_in[1] = 1'b1;
        steps(5, "t3_sync",    5'h00, 5'h00, 5'h00, 5'h00);
        steps(1, "t3_press",   5'h02, 5'h02, 5'h00, 5'h00);
        steps(1, "t3_pr_low",  5'h02, 5'h00, 5'h00, 5'h00);
        btn_in = 5'b00000;
        steps(5, "t3_relwait", 5'h02, 5'h00, 5'h00, 5'h00);
        steps(1, "t3_rel",     5'h00, 5'h00, 5'h02, 5'h00);
        steps(2, "t3_idle",    5'h00, 5'h00, 5'h00, 5'h00);

        // 4: long press on channel 2, held 20 cycles after the press pulse
        btn_in = 5'b00100;
        steps(5,  "t4_sync",     5'h00, 5'h00, 5'h00, 5'h00);
        steps(1,  "t4_press",    5'h04, 5'h04, 5'h00, 5'h00);
        steps(9,  "t4_hold",     5'h04, 5'h00, 5'h00, 5'h00);
        steps(1,  "t4_long",     5'h04, 5'h00, 5'h00, 5'h04);
        steps(10, "t4_no_repeat", 5'h04, 5'h00, 5'h00, 5'h00);
        btn_in = 5'b00000;
        steps(5, "t4_relwait", 5'h04, 5'h00, 5'h00, 5'h00);
        steps(1, "t4_rel",     5'h00, 5'h00, 5'h04, 5'h00);
        steps(2, "t4_idle",    5'h00, 5'h00, 5'h00, 5'h00);

        // 5: short press on channel 3, level high for 5 cycles
        btn_in = 5'b01000;
        steps(5, "t5_sync",  5'h00, 5'h00, 5'h00, 5'h00);
        btn_in = 5'b00000;
        steps(1, "t5_press", 5'h08, 5'h08, 5'h00, 5'h00);
        steps(4, "t5_high",  5'h08, 5'h00, 5'h00, 5'h00);
        steps(1, "t5_rel",   5'h00, 5'h00, 5'h08, 5'h00);
        steps(3, "t5_idle",  5'h00, 5'h00, 5'h00, 5'h00);

        // 6: reset at hold count 7 on channel 2, input stays high across reset
        btn_in = 5'b00100;
        steps(5, "t6_sync",  5'h00, 5'h00, 5'h00, 5'h00);
        steps(1, "t6_press", 5'h04, 5'h04, 5'h00, 5'h00);
        steps(7, "t6_hold",  5'h04, 5'h00, 5'h00, 5'h00);
        rst_n = 1'b0;
        #1;
        expect_now("t6_async_clear", 5'h00, 5'h00, 5'h00, 5'h00);
        check_out();
        steps(2, "t6_in_reset", 5'h00, 5'h00, 5'h00, 5'h00);
        rst_n = 1'b1;
        steps(5, "t6_sync2",  5'h00, 5'h00, 5'h00, 5'h00);
        steps(1, "t6_press2", 5'h04, 5'h04, 5'h00, 5'h00);
        steps(9, "t6_hold2",  5'h04, 5'h00, 5'h00, 5'h00);
        steps(1, "t6_long2",  5'h04, 5'h00, 5'h00, 5'h04);
        steps(3, "t6_after",  5'h04, 5'h00, 5'h00, 5'h00);
        btn_in = 5'b00000;
        steps(5, "t6_relwait", 5'h04, 5'h00, 5'h00, 5'h00);
        steps(1, "t6_rel",     5'h00, 5'h00, 5'h04, 5'h00);
        steps(2, "t6_idle",    5'h00, 5'h00, 5'h00, 5'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Parametrised multi-channel input conditioner for the OTTER board wrapper.
- Per channel, it synchronises the raw push-button or switch inputs, debounces them, and emits a clean level plus single-cycle press, release and long-press pulses.
- It sits between the board pins and the wrapper's button/switch consumers, such as the MCU interrupt, the IOBUS input and the reset source.
- It replaces ad-hoc per-button handling with one block generalised in channel count, debounce time and hold detection.

Parameters:
- N, 5, number of independent channels (N >= 1).
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles needed to accept a new level (>= 1).
- HOLD_CYCLES, 50000000, clk cycles the debounced level must stay high before long_press fires (>= 1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- btn_in  input  N  raw asynchronous inputs; bit i is channel i.
- db_level  output  N  debounced, registered level per channel.
- press_pulse  output  N  1-cycle pulse when db_level[i] rises.
- release_pulse  output  N  1-cycle pulse when db_level[i] falls.
- long_press  output  N  1-cycle pulse when a press has been held HOLD_CYCLES cycles.

Behaviour:
- Reset (rst_n=0, asynchronous): the following clear to 0 immediately, independent of clk and btn_in:
  - synchroniser flops;
  - debounce counters;
  - hold counters;
  - long-press done flags;
  - db_level, press_pulse, release_pulse and long_press.
- Synchroniser: two-flop chain per channel, so sync[i] lags btn_in[i] by 2 clk edges.
- Debounce, per channel, evaluated every clk edge:
  - sync[i] == db_level[i]: debounce counter resets to 0.
  - sync[i] != db_level[i]: counter increments.
  - On the edge where the counter would reach DEBOUNCE_CYCLES: db_level[i] toggles and the counter resets to 0.
  - Net latency from btn_in change (setup before edge 0) to db_level change is 2 + DEBOUNCE_CYCLES edges, provided the input stays stable.
  - Any mismatch-free cycle restarts the count, so bounces shorter than DEBOUNCE_CYCLES never propagate.
- Counter width: $clog2(DEBOUNCE_CYCLES+1). The counter never wraps because it is cleared on acceptance.
- Pulses are registered and assert on the same edge db_level changes, high for exactly 1 cycle:
  - press_pulse[i] on a 0->1 change;
  - release_pulse[i] on a 1->0 change.
  - press_pulse and release_pulse are never both high on one channel in the same cycle.
- Hold detection, per channel:
  - The hold counter clears on the press edge.
  - It increments every cycle db_level[i]=1 and saturates at HOLD_CYCLES; width $clog2(HOLD_CYCLES+1).
  - long_press[i] pulses for 1 cycle on the edge the counter reaches HOLD_CYCLES, i.e. HOLD_CYCLES cycles after the press_pulse cycle.
  - It fires at most once per press. The counter and done flag clear on release.
  - A release accepted on the same edge the count would reach HOLD_CYCLES suppresses long_press.
- Channels are fully independent. Simultaneous events on several channels each produce their own pulses in the same cycle.
- Input high during reset: after rst_n deasserts, it is treated as a new press. db_level rises 2 + DEBOUNCE_CYCLES edges later, with press_pulse.
- Reset asserted mid-debounce or mid-hold:
  - all counts are lost and all outputs go to 0;
  - no release_pulse is generated for the forced drop.
- No combinational path from btn_in to any output.

Test Plan:
All scenarios use N=5, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10 and a 20 ns clk.
1. Hold rst_n=0 with btn_in=5'b11111, then assert rst_n=1 -> all outputs 0 during reset. Edge 6 after release: db_level=5'b11111 and press_pulse=5'b11111 for exactly 1 cycle.
2. Clean press: btn_in[0] 0->1 before edge 0 and held -> db_level[0]=1 and press_pulse[0]=1 at edge 6. press_pulse[0]=0 at edge 7. Other channels stay 0.
3. Bounce: btn_in[1] toggles every 2 cycles for 12 cycles, then settles at 1 -> no activity during the bounce. db_level[1] rises exactly 6 edges after the final transition, with a single press_pulse.
4. Long press: btn_in[2] held for 20 cycles after press_pulse -> long_press[2] single 1-cycle pulse 10 cycles after press_pulse, never repeated. Release -> release_pulse[2] at 2+4 edges after the btn_in fall.
5. Short press: btn_in[3] high long enough for db_level to be high 5 cycles, then released -> press_pulse[3] and release_pulse[3] each pulse once. long_press[3] never asserts.
6. Reset mid-operation: rst_n=0 at hold count 7 on channel 2 -> immediate all-zero outputs and no release_pulse. After rst_n=1 with btn_in[2] still 1 -> new press_pulse at edge 6 and long_press 10 cycles later.
